// File: rtl/hello_scroller_if.sv
// Bundle between the switch/key front end and the scroller.
// The front end drives the controls; the scroller returns the
// per-display character codes, the advance pulse and the rotation index.
interface hello_scroller_if;
    logic        run;
    logic        step;
    logic        dir;
    logic        clear;
    logic [23:0] codes;
    logic        adv;
    logic [2:0]  ptr;

    modport master (
        output run, step, dir, clear,
        input  codes, adv, ptr
    );

    modport slave (
        input  run, step, dir, clear,
        output codes, adv, ptr
    );
endinterface

// File: rtl/hello_scroller.sv
// Message scroller for eight character decoders (HEX7..HEX0).
// Rotates "HELLO   " across the displays, either free-running at one
// advance per TICK_DIV clocks or one advance per step pulse while stopped.
// The divider is a down-counter holding the clocks left before the next
// run-mode advance; it freezes while stopped so a resume keeps its phase.
module hello_scroller #(
    parameter int TICK_DIV = 50000000
) (
    input logic             i_clock,
    input logic             i_resetn,
    hello_scroller_if.slave bus
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICK_DIV - 1);

    localparam logic [2:0] CODE_H     = 3'b000;
    localparam logic [2:0] CODE_E     = 3'b001;
    localparam logic [2:0] CODE_L     = 3'b010;
    localparam logic [2:0] CODE_O     = 3'b011;
    localparam logic [2:0] CODE_BLANK = 3'b111;

    logic [2:0]       r_ptr;
    logic [DIV_W-1:0] r_div_left;
    logic             r_adv;

    logic             w_div_tc;
    logic             w_advance;
    logic [DIV_W-1:0] w_div_left_next;
    logic [2:0]       w_ptr_step;
    logic [23:0]      w_codes;

    // Message ROM: slot index -> character code.
    function automatic logic [2:0] msg_code(input logic [2:0] slot);
        logic [2:0] code;
        case (slot)
            3'd0:    code = CODE_H;
            3'd1:    code = CODE_E;
            3'd2:    code = CODE_L;
            3'd3:    code = CODE_L;
            3'd4:    code = CODE_O;
            default: code = CODE_BLANK;
        endcase
        return code;
    endfunction

    assign w_div_tc   = (r_div_left == '0);
    assign w_ptr_step = bus.dir ? (r_ptr - 3'd1) : (r_ptr + 3'd1);

    // Advance decision and divider next value; clear beats run, run beats step.
    always_comb begin
        w_advance       = 1'b0;
        w_div_left_next = r_div_left;
        if (bus.clear) begin
            w_div_left_next = DIV_RELOAD;
        end else if (bus.run) begin
            if (w_div_tc) begin
                w_div_left_next = DIV_RELOAD;
                w_advance       = 1'b1;
            end else begin
                w_div_left_next = r_div_left - 1'b1;
            end
        end else if (bus.step) begin
            w_advance = 1'b1;
        end
    end

    // State registers: rotation index, divider and the advance pulse.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ptr      <= 3'd0;
            r_div_left <= DIV_RELOAD;
            r_adv      <= 1'b0;
        end else begin
            r_div_left <= w_div_left_next;
            r_adv      <= w_advance;
            if (bus.clear) begin
                r_ptr <= 3'd0;
            end else if (w_advance) begin
                r_ptr <= w_ptr_step;
            end
        end
    end

    // Display k shows message slot (ptr + 7 - k) mod 8, decoded from ptr only.
    always_comb begin
        w_codes = '0;
        for (int k = 0; k < 8; k++) begin
            w_codes[3*k +: 3] = msg_code(r_ptr + 3'd7 - 3'(k));
        end
    end

    assign bus.codes = w_codes;
    assign bus.adv   = r_adv;
    assign bus.ptr   = r_ptr;

endmodule

// File: tb/tb_hello_scroller.sv
// Bench for hello_scroller with TICK_DIV=4: directed scenarios followed by
// random control traffic, checked against a message/rotation model.
module tb_hello_scroller;

    localparam int TICK_DIV = 4;

    typedef struct {
        logic [2:0]  ptr;
        logic [23:0] codes;
    } adv_t;

    logic clk;
    logic rst_n;

    hello_scroller_if bus();

    hello_scroller #(.TICK_DIV(TICK_DIV)) dut (
        .i_clock  (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    adv_t sb[$];

    int   m_ptr = 0;
    int   m_div = 0;
    bit   m_adv = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected HEX7..HEX0 codes for a rotation index, read from the message text.
    function automatic logic [23:0] exp_codes(input int p);
        string       msg;
        logic [23:0] c;
        msg = "HELLO   ";
        c   = '0;
        for (int k = 0; k < 8; k++) begin
            byte ch;
            ch = msg[(p + 7 - k) % 8];
            case (ch)
                "H":     c[3*k +: 3] = 3'b000;
                "E":     c[3*k +: 3] = 3'b001;
                "L":     c[3*k +: 3] = 3'b010;
                "O":     c[3*k +: 3] = 3'b011;
                default: c[3*k +: 3] = 3'b111;
            endcase
        end
        return c;
    endfunction

    // Drive one cycle of controls (we sit at a negedge), predict, then check.
    task automatic tick(input bit run, input bit step, input bit dir, input bit clr);
        bit   advd;
        adv_t e;
        advd      = 1'b0;
        bus.run   = run;
        bus.step  = step;
        bus.dir   = dir;
        bus.clear = clr;
        if (clr) begin
            m_ptr = 0;
            m_div = 0;
        end else if (run) begin
            if (m_div == TICK_DIV - 1) begin
                m_div = 0;
                advd  = 1'b1;
            end else begin
                m_div++;
            end
        end else if (step) begin
            advd = 1'b1;
        end
        if (advd) begin
            m_ptr   = dir ? (m_ptr + 7) % 8 : (m_ptr + 1) % 8;
            e.ptr   = 3'(m_ptr);
            e.codes = exp_codes(m_ptr);
            sb.push_back(e);
        end
        m_adv = advd;
        @(negedge clk);
        check("ptr", 32'(bus.ptr), 32'(m_ptr));
        check("adv", 32'(bus.adv), 32'(m_adv));
    endtask

    // Scoreboard monitor: every adv pulse must match the oldest predicted advance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.adv === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL adv_unexpected at %0t: got adv=1 expected no advance", $time);
            end else begin
                adv_t e;
                e = sb.pop_front();
                check("sb_ptr", 32'(bus.ptr), 32'(e.ptr));
                check("sb_codes", 32'(bus.codes), 32'(e.codes));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_seen;
        bus.run   = 1'b0;
        bus.step  = 1'b0;
        bus.dir   = 1'b0;
        bus.clear = 1'b0;
        rst_n     = 1'b0;

        // 1: reset state
        repeat (2) @(negedge clk);
        check("rst_ptr", 32'(bus.ptr), 0);
        check("rst_adv", 32'(bus.adv), 0);
        check("rst_codes", 32'(bus.codes), 32'(24'b000_001_010_010_011_111_111_111));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ptr", 32'(bus.ptr), 0);
        check("rel_codes", 32'(bus.codes), 32'(24'b000_001_010_010_011_111_111_111));

        // 2: free-run left, eight advances back to ptr 0
        n_seen = 0;
        for (int i = 0; i < 8 * TICK_DIV; i++) begin
            tick(1, 0, 0, 0);
            if (bus.adv === 1'b1) n_seen++;
            if (i == TICK_DIV - 1) begin
                check("run_l_first_ptr", 32'(bus.ptr), 1);
                check("run_l_first_codes", 32'(bus.codes), 32'(24'b001_010_010_011_111_111_111_000));
            end
        end
        check("run_l_adv_count", 32'(n_seen), 8);
        check("run_l_wrap_ptr", 32'(bus.ptr), 0);

        // 3: free-run right from clear, 0->7 wrap
        tick(0, 0, 0, 1);
        for (int i = 0; i < TICK_DIV; i++) tick(1, 0, 1, 0);
        check("run_r_ptr", 32'(bus.ptr), 7);
        check("run_r_codes", 32'(bus.codes), 32'(24'b111_000_001_010_010_011_111_111));

        // 4: step while stopped; step ignored while running
        tick(0, 0, 0, 1);
        tick(0, 1, 0, 0);
        check("step_ptr", 32'(bus.ptr), 1);
        check("step_adv", 32'(bus.adv), 1);
        tick(0, 0, 0, 0);
        check("step_adv_drop", 32'(bus.adv), 0);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        check("step_in_run_ptr", 32'(bus.ptr), 0);
        tick(1, 0, 0, 0);
        check("run_cadence_ptr", 32'(bus.ptr), 1);

        // 5: pause holds divider phase; clear beats step
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("resume_no_adv", 32'(bus.adv), 0);
        tick(1, 0, 0, 0);
        check("resume_adv", 32'(bus.adv), 1);
        check("resume_ptr", 32'(bus.ptr), 1);
        tick(1, 1, 0, 1);
        check("clear_ptr", 32'(bus.ptr), 0);
        check("clear_adv", 32'(bus.adv), 0);

        // 6: async reset mid-count at ptr 5
        tick(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
        for (int i = 0; i < TICK_DIV - 1; i++) tick(1, 0, 0, 0);
        check("pre_rst_ptr", 32'(bus.ptr), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ptr", 32'(bus.ptr), 0);
        check("async_rst_adv", 32'(bus.adv), 0);
        check("async_rst_codes", 32'(bus.codes), 32'(24'b000_001_010_010_011_111_111_111));
        sb.delete();
        m_ptr = 0;
        m_div = 0;
        m_adv = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TICK_DIV - 1; i++) tick(1, 0, 0, 0);
        check("post_rst_no_adv", 32'(bus.adv), 0);
        tick(1, 0, 0, 0);
        check("post_rst_adv_ptr", 32'(bus.ptr), 1);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31) == 0);
        end

        tick(0, 0, 0, 0);
        check("sb_drain", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
